// File: rtl/push_rs232tx.sv
// RS232 8N1 transmitter, LSB first, with a one-byte push holding register and CTS flow control.
// Frames start only while the synchronized clear-to-send input is low.
module push_rs232tx #(
  parameter real CLOCK_FREQ = 133000000.0,
  parameter real BAUD_RATE  = 115200.0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] idata,
  input  logic       istrobe,
  output logic       iready,
  output logic       txd_pin,
  input  logic       ctsn_pin
);

  localparam int BaudCountFull = int'(CLOCK_FREQ / BAUD_RATE);
  localparam int CntW          = $clog2(BaudCountFull) + 1;

  // Counter reloads to N-2 and ticks on wrap to all-ones, giving N clocks per bit.
  localparam logic [CntW-1:0] CntReload = CntW'(BaudCountFull - 2);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic            txd_q, txd_d;
  logic            hold_full_q, hold_full_d;
  logic [7:0]      hold_q, hold_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cts_meta_q, cts_n_q;

  logic tick;
  logic start_ok;

  assign tick     = cnt_q[CntW-1];
  assign start_ok = hold_full_q && !cts_n_q;
  assign iready   = !hold_full_q;
  assign txd_pin  = txd_q;

  always_comb begin
    state_d     = state_q;
    txd_d       = txd_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    cnt_d       = cnt_q;

    if (state_q != StIdle) begin
      cnt_d = tick ? CntReload : (cnt_q - CntOne);
    end

    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (start_ok) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = CntReload;
          txd_d       = 1'b0;
          state_d     = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          txd_d     = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = StStop;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (start_ok) begin
            // Back-to-back frame: no idle gap after the stop bit.
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = CntReload;
            txd_d       = 1'b0;
            state_d     = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Push and transfer are exclusive: push needs empty, transfer needs full.
    if (istrobe && !hold_full_q) begin
      hold_d      = idata;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      txd_q       <= 1'b1;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      cnt_q       <= '0;
      cts_meta_q  <= 1'b1;
      cts_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      txd_q       <= txd_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      cnt_q       <= cnt_d;
      cts_meta_q  <= ctsn_pin;
      cts_n_q     <= cts_meta_q;
    end
  end

endmodule
